// File: rtl/arb_rr_4.sv
// arb_rr_4: four-requester arbiter for the shared downstream port.
// One owner at a time; the grant is held until done, a request drop, or
// hold expiry. The next owner is chosen by fixed priority (bit 3 highest)
// or by round-robin starting just below the previous owner.
module arb_rr_4 #(
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [1:0]      last_id;
    logic [CW-1:0]   hold_cnt;

    logic [1:0]      start;
    logic [1:0]      idx;
    logic [1:0]      pick_id;
    logic            found;
    logic            owner_req;
    logic            expire;
    logic            release_now;

    // Winner selection: descending search from start, wrapping modulo 4.
    // Fixed mode always starts at 3; round-robin starts one below the last owner.
    always_comb begin
        start   = (RR_MODE != 0) ? (last_id - 2'd1) : 2'd3;
        pick_id = 2'd0;
        found   = 1'b0;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start - 2'(i);
            if (!found && req[idx]) begin
                pick_id = idx;
                found   = 1'b1;
            end
        end
    end

    // Release conditions for the current owner.
    always_comb begin
        owner_req   = req[grant_id];
        expire      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        release_now = done || !owner_req || expire;
    end

    // Grant FSM with registered outputs; timeout flags only a pure expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_id     <= 2'd0;
            hold_cnt    <= '0;
            grant       <= 4'b0000;
            grant_id    <= 2'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (req != 4'b0000) begin
                        state       <= BUSY;
                        grant       <= 4'd1 << pick_id;
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant       <= 4'b0000;
                        grant_id    <= 2'd0;
                        grant_valid <= 1'b0;
                        last_id     <= grant_id;
                        timeout     <= expire && !done && owner_req;
                    end else begin
                        timeout <= 1'b0;
                        if (hold_cnt != {CW{1'b1}})
                            hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_rr_4.sv
// Bench for arb_rr_4: one fixed-priority and one round-robin instance
// (both MAX_HOLD=4), driven from per-cycle vector tables. Expected
// outputs are queued when a vector is driven and compared after the edge.
module tb_arb_rr_4;

    logic       clk;
    logic       rst;
    logic [3:0] req_f, req_r;
    logic       done_f, done_r;
    logic [3:0] grant_f, grant_r;
    logic [1:0] id_f, id_r;
    logic       valid_f, valid_r;
    logic       to_f, to_r;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] id;
        logic       valid;
        logic       to;
    } out_t;

    typedef struct {
        bit         sel_rr;
        logic [3:0] req;
        logic       done;
        out_t       exp;
    } vec_t;

    typedef struct {
        bit   sel_rr;
        out_t exp;
        int   num;
    } sb_t;

    vec_t vec_a[$];
    vec_t vec_b[$];
    vec_t vec_c[$];
    sb_t  exp_q[$];

    arb_rr_4 #(.RR_MODE(0), .MAX_HOLD(4)) u_fx (
        .clk(clk), .rst(rst), .req(req_f), .done(done_f),
        .grant(grant_f), .grant_id(id_f), .grant_valid(valid_f), .timeout(to_f)
    );

    arb_rr_4 #(.RR_MODE(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst(rst), .req(req_r), .done(done_r),
        .grant(grant_r), .grant_id(id_r), .grant_valid(valid_r), .timeout(to_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit rr, logic [3:0] r, logic d,
                                logic [3:0] g, logic [1:0] id, logic v, logic t);
        vec_t x;
        x.sel_rr = rr;
        x.req    = r;
        x.done   = d;
        x.exp    = '{grant: g, id: id, valid: v, to: t};
        return x;
    endfunction

    function automatic out_t act(bit rr);
        if (rr) return '{grant: grant_r, id: id_r, valid: valid_r, to: to_r};
        return '{grant: grant_f, id: id_f, valid: valid_f, to: to_f};
    endfunction

    task automatic cmp(string name, int num, out_t got, out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s #%0d: got grant=%b id=%0d valid=%b to=%b, want grant=%b id=%0d valid=%b to=%b",
                     name, num, got.grant, got.id, got.valid, got.to,
                     want.grant, want.id, want.valid, want.to);
        end
    endtask

    // Drive one vector, queue its expectation, compare after the edge.
    task automatic step(vec_t v, int num);
        sb_t e;
        sb_t p;
        req_f  = v.sel_rr ? 4'b0000 : v.req;
        done_f = v.sel_rr ? 1'b0 : v.done;
        req_r  = v.sel_rr ? v.req : 4'b0000;
        done_r = v.sel_rr ? v.done : 1'b0;
        e.sel_rr = v.sel_rr;
        e.exp    = v.exp;
        e.num    = num;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        p = exp_q.pop_front();
        cmp(p.sel_rr ? "rr_vec" : "fx_vec", p.num, act(p.sel_rr), p.exp);
    endtask

    initial begin
        // Fixed priority: grant to bit 2 of 0110, then interrupted by reset.
        vec_a.push_back(mk(0, 4'b0110, 0, 4'b0100, 2, 1, 0));
        vec_a.push_back(mk(0, 4'b0110, 0, 4'b0100, 2, 1, 0));

        // After reset release: re-grant, then hold req[2] alone to expiry.
        vec_b.push_back(mk(0, 4'b0110, 0, 4'b0100, 2, 1, 0)); // cnt 0
        vec_b.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0)); // cnt 1
        vec_b.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0)); // cnt 2
        vec_b.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0)); // cnt 3
        vec_b.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 0, 1)); // timeout
        vec_b.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0)); // re-grant
        // done coincides with expiry: normal release
        vec_b.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0));
        vec_b.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0));
        vec_b.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0));
        vec_b.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, 0, 0));
        // owner 1, req[3] toggles without preempting, then owner drops
        vec_b.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 0));
        vec_b.push_back(mk(0, 4'b1010, 0, 4'b0010, 1, 1, 0));
        vec_b.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 0));
        vec_b.push_back(mk(0, 4'b1000, 0, 4'b0000, 0, 0, 0));
        vec_b.push_back(mk(0, 4'b1000, 0, 4'b1000, 3, 1, 0));
        vec_b.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));
        vec_b.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));

        // Round-robin rotation with req=1111, done in each grant's 2nd cycle.
        for (int k = 0; k < 5; k++) begin
            logic [1:0] id;
            logic [3:0] g;
            id = 2'(3 - (k % 4));
            g  = 4'd1 << id;
            vec_c.push_back(mk(1, 4'b1111, 0, g, id, 1, 0));
            if (k < 4) vec_c.push_back(mk(1, 4'b1111, 0, g, id, 1, 0));
            vec_c.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
        end
        // Skip: req=1001 after owner 3 released.
        vec_c.push_back(mk(1, 4'b1001, 0, 4'b0001, 0, 1, 0));
        vec_c.push_back(mk(1, 4'b1001, 1, 4'b0000, 0, 0, 0));
        vec_c.push_back(mk(1, 4'b1001, 0, 4'b1000, 3, 1, 0));
        vec_c.push_back(mk(1, 4'b1001, 1, 4'b0000, 0, 0, 0));
        vec_c.push_back(mk(1, 4'b1001, 0, 4'b0001, 0, 1, 0));
        vec_c.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));

        rst    = 1'b1;
        req_f  = 4'b0000;
        req_r  = 4'b0000;
        done_f = 1'b0;
        done_r = 1'b0;
        #12;
        cmp("reset_fx", 0, act(0), '0);
        cmp("reset_rr", 0, act(1), '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vec_a.size(); i++) step(vec_a[i], i);

        // Reset mid-grant must clear outputs without a clock edge.
        #3;
        rst = 1'b1;
        #1;
        cmp("async_rst_fx", 0, act(0), '0);
        cmp("async_rst_rr", 0, act(1), '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vec_b.size(); i++) step(vec_b[i], 100 + i);
        for (int i = 0; i < vec_c.size(); i++) step(vec_c[i], 200 + i);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb_rr_4.md
# arb_rr_4

Four-requester arbiter that shares one downstream resource (the 4:2 priority-encoded datapath port) between requesters `req[3:0]`. It grants one requester at a time, holds the grant until release or timeout, and selects the next owner by fixed priority (bit 3 highest) or by round-robin. It sits between the request sources and the shared resource. It drives the one-hot grant plus the encoded owner index, in the same 2-bit encoding as the priority encoder.

## Interface
Parameters:
- `RR_MODE`, default 1: 1 = round-robin selection; 0 = fixed priority, `req[3]` > `req[2]` > `req[1]` > `req[0]`.
- `MAX_HOLD`, default 16: maximum cycles a grant may be held before forced release. 0 disables the timeout.

Ports:
- `clk`, input, 1: single clock, all state changes on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 4: request lines, level-sensitive, one per requester.
- `done`, input, 1: single-cycle release from the current owner. Ignored when no grant is active.
- `grant`, output, 4: one-hot grant, registered. All zero when idle.
- `grant_id`, output, 2: encoded index of the owner, registered. Valid only when `grant_valid`=1.
- `grant_valid`, output, 1: a grant is active. Equals OR of `grant`.
- `timeout`, output, 1: one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- FSM states:
  - IDLE: no owner. Reset state.
  - BUSY: one owner holds the grant.
- IDLE -> BUSY at a rising edge where `req` != 0. The winner is chosen from `req` sampled at that edge. Sets `grant`, `grant_id`, `grant_valid`, and clears the hold counter.
- Selection, fixed mode: highest set index wins.
- Selection, round-robin mode:
  - Search descending from `(last_id - 1) mod 4`, wrapping; the first set bit wins.
  - `last_id` is an internal 2-bit register, reset to 0, so the first search order after reset is 3,2,1,0, identical to fixed priority.
- BUSY -> IDLE at the first edge where any of the following holds:
  - `done`=1.
  - `req[grant_id]`=0 (owner dropped its request).
  - `MAX_HOLD`!=0 and the hold counter equals `MAX_HOLD-1`.
- On BUSY -> IDLE:
  - `grant`, `grant_id` and `grant_valid` clear.
  - `last_id` <= released `grant_id`. This update happens in both modes; only round-robin uses it.
- `timeout` is 1 for one cycle (the cycle after the release edge) only when the counter condition alone caused the release. If `done` or the request drop coincides with expiry, it is a normal release and `timeout`=0.
- Hold counter:
  - Width `$clog2(MAX_HOLD+1)`, minimum 1.
  - Increments every BUSY cycle; saturates.
  - Cleared on entry to BUSY.
- Changes on non-owner `req` bits during BUSY are ignored. There is no preemption, even in fixed mode.
- `req`=0 in IDLE: stay IDLE, all outputs 0.

## Timing
- Reset values: `grant`=4'b0000, `grant_id`=2'b00, `grant_valid`=0, `timeout`=0. Internally, state=IDLE, `last_id`=0, counter=0.
- Assertion of `rst` mid-grant clears every output immediately, with no clock edge needed.
- Grant latency: `req` high before edge N gives `grant` high after edge N, i.e. 1 cycle.
- Release latency: `done` high at edge M gives `grant` low after edge M.
- There is always at least one idle cycle between consecutive grants. With continuous requests, the minimum period is hold + 1 cycle.
- A timed-out grant with `MAX_HOLD`=H is visible for exactly H cycles.
- `timeout` is asserted in the same cycle that `grant_valid` first reads 0.

## Test plan
- Reset and fixed priority:
  - Stimulus: assert `rst` during BUSY, then release it; `RR_MODE`=0, `req`=4'b0110.
  - Required: outputs go to 0 asynchronously. One cycle after `rst` release, `grant`=4'b0100 and `grant_id`=2.
- Round-robin rotation:
  - Stimulus: `RR_MODE`=1, `req`=4'b1111 held, `done` pulsed in the second cycle of each grant.
  - Required: `grant_id` sequence 3,2,1,0,3, with `grant_valid`=0 for one cycle between grants.
- Round-robin skip:
  - Stimulus: `req`=4'b1001; owner 3 releases.
  - Required: next `grant_id`=0. After 0 releases, next is 3.
- Timeout:
  - Stimulus: `MAX_HOLD`=4; `req[2]` held, `done`=0.
  - Required: `grant`=4'b0100 for exactly 4 cycles, then `timeout`=1 for 1 cycle with `grant`=0, then requester 2 is re-granted if it is the only requester.
- Simultaneous release:
  - Stimulus: `done`=1 at the edge where the counter reaches `MAX_HOLD-1`.
  - Required: release occurs and `timeout` stays 0.
- Request drop and non-owner changes:
  - Stimulus: owner 1 deasserts `req[1]` mid-grant; `req[3]` toggles during BUSY.
  - Required: grant ends on the next edge, `req[3]` is never granted early, and there is no preemption.
